pll_reset_sequencer: RTL and testbench

- Consumes the `locked` output of the board PLL (16 MHz in, 120 MHz out) and generates the synchronous-deassert system reset for all logic in the PLL output domain.
- Synchronises `locked` into the `clock` domain and holds `sys_reset_n` low until lock has been continuously stable for a programmable time.
- In run mode, filters lock-loss glitches. On confirmed lock loss it re-asserts reset, counts the event and restarts the sequence.
- Sits between the PLL wrapper and the motor-control top level.

---
 rtl/pll_reset_sequencer.sv | 127 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// Synchronises PLL lock and sequences the system reset. Reset is released only after lock has
// been stable long enough, and it is re-asserted when lock is lost for long enough.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1200,
  parameter int unsigned LOSS_FILTER_CYCLES = 4,
  parameter int unsigned CNT_WIDTH          = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 clear_count,
  output logic                 sys_reset_n,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] lock_lost_count
);

  localparam int unsigned StableW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int unsigned FiltW   = (LOSS_FILTER_CYCLES > 1) ? $clog2(LOSS_FILTER_CYCLES) : 1;
  localparam logic [StableW-1:0] StableLast = StableW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [FiltW-1:0]   FiltLast   = FiltW'(LOSS_FILTER_CYCLES - 1);

  typedef enum logic [1:0] {StWaitLock, StStabilize, StRun, StLost} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [StableW-1:0]     stable_q, stable_d;
  logic [FiltW-1:0]       filt_q, filt_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   lost_q, lost_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   locked_s;
  logic                   loss_event;

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    filt_d      = filt_q;
    sys_rst_n_d = 1'b0;
    lost_d      = 1'b0;
    loss_event  = 1'b0;
    case (state_q)
      StWaitLock: begin
        stable_d = '0;
        filt_d   = '0;
        if (locked_s) state_d = StStabilize;
      end
      StStabilize: begin
        if (!locked_s) begin
          // Any dropout forfeits the accumulated stable time.
          state_d  = StWaitLock;
          stable_d = '0;
        end else if (stable_q == StableLast) begin
          state_d     = StRun;
          stable_d    = '0;
          sys_rst_n_d = 1'b1;
        end else begin
          stable_d = stable_q + StableW'(1);
        end
      end
      StRun: begin
        sys_rst_n_d = 1'b1;
        if (!locked_s) begin
          if (filt_q == FiltLast) begin
            state_d     = StLost;
            filt_d      = '0;
            sys_rst_n_d = 1'b0;
            lost_d      = 1'b1;
            loss_event  = 1'b1;
          end else begin
            filt_d = filt_q + FiltW'(1);
          end
        end else begin
          filt_d = '0;
        end
      end
      StLost: begin
        state_d = StWaitLock;
        filt_d  = '0;
      end
      default: state_d = StWaitLock;
    endcase
  end

  // A clear coinciding with a new loss keeps that loss.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = loss_event ? CNT_WIDTH'(1) : '0;
    end else if (loss_event && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWaitLock;
      stable_q    <= '0;
      filt_q      <= '0;
      sys_rst_n_q <= 1'b0;
      lost_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      filt_q      <= filt_d;
      sys_rst_n_q <= sys_rst_n_d;
      lost_q      <= lost_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sys_reset_n     = sys_rst_n_q;
  assign lock_lost       = lost_q;
  assign lock_lost_count = cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a streak-based lock model checked every cycle,
// plus literal edge-count expectations from the test plan.
module tb_pll_reset_sequencer;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned StableCyc  = 16;
  localparam int unsigned LossCyc    = 4;
  localparam int unsigned CntW       = 4;
  localparam int unsigned CntMax     = (1 << CntW) - 1;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            locked = 1'b0;
  logic            clear_count = 1'b0;
  logic            sys_reset_n;
  logic            lock_lost;
  logic [CntW-1:0] lock_lost_count;

  int n_cmp = 0;
  int n_fail = 0;

  // Model: input history, streak of stable lock while not running, streak of loss while running.
  bit hist [SyncStages];
  int m_hi, m_lo, m_cnt;
  bit m_run, m_in_lost, m_pulse;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SyncStages),
    .LOCK_STABLE_CYCLES(StableCyc),
    .LOSS_FILTER_CYCLES(LossCyc),
    .CNT_WIDTH         (CntW)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .locked         (locked),
    .clear_count    (clear_count),
    .sys_reset_n    (sys_reset_n),
    .lock_lost      (lock_lost),
    .lock_lost_count(lock_lost_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(SyncStages); i++) hist[i] = 1'b0;
    m_hi = 0; m_lo = 0; m_cnt = 0;
    m_run = 1'b0; m_in_lost = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge();
    bit ls;
    bit ev;
    ls = hist[SyncStages-1];
    for (int i = int'(SyncStages) - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = locked;
    ev = 1'b0;
    if (m_in_lost) begin
      m_in_lost = 1'b0;
    end else if (!m_run) begin
      m_hi = ls ? m_hi + 1 : 0;
      if (m_hi == int'(StableCyc) + 1) begin
        m_run = 1'b1;
        m_hi  = 0;
      end
    end else begin
      m_lo = ls ? 0 : m_lo + 1;
      if (m_lo == int'(LossCyc)) begin
        m_run = 1'b0;
        m_lo = 0;
        m_in_lost = 1'b1;
        ev = 1'b1;
      end
    end
    m_pulse = ev;
    if (clear_count) m_cnt = ev ? 1 : 0;
    else if (ev && m_cnt < int'(CntMax)) m_cnt++;
  endtask

  // One clock edge: advance the model on the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    chk("model sys_reset_n", {31'b0, sys_reset_n}, {31'b0, m_run});
    chk("model lock_lost", {31'b0, lock_lost}, {31'b0, m_pulse});
    chk("model lock_lost_count", {28'b0, lock_lost_count}, m_cnt);
  endtask

  // Raise lock (held) and expect release on exactly the 19th edge.
  task automatic acquire(input string name);
    locked = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 18) chk({name, " low at edge 18"}, {31'b0, sys_reset_n}, 0);
      if (k == 19) chk({name, " high at edge 19"}, {31'b0, sys_reset_n}, 1);
    end
  endtask

  // Force one confirmed loss from RUN, optionally clearing on the loss edge, then reacquire.
  task automatic do_loss(input bit clr);
    locked = 1'b0;
    repeat (5) step();
    clear_count = clr;
    step();
    clear_count = 1'b0;
    chk("loss pulse", {31'b0, lock_lost}, 1);
    repeat (2) step();
    acquire("reacquire");
  endtask

  task automatic async_reset(input string name);
    reset_n = 1'b0;
    #1;
    chk({name, " immediate sys_reset_n"}, {31'b0, sys_reset_n}, 0);
    chk({name, " immediate count"}, {28'b0, lock_lost_count}, 0);
    chk({name, " immediate lock_lost"}, {31'b0, lock_lost}, 0);
    model_reset();
    step();
    reset_n = 1'b1;
    // locked is still high, so release follows the full sequence from reset release.
    for (int k = 1; k <= 19; k++) begin
      step();
      if (k == 18) chk({name, " low at edge 18"}, {31'b0, sys_reset_n}, 0);
      if (k == 19) chk({name, " high at edge 19"}, {31'b0, sys_reset_n}, 1);
    end
  endtask

  initial begin
    model_reset();
    repeat (3) step();
    chk("reset sys_reset_n", {31'b0, sys_reset_n}, 0);
    chk("reset count", {28'b0, lock_lost_count}, 0);
    reset_n = 1'b1;
    repeat (2) step();

    // 1: acquisition latency
    acquire("t1");
    chk("t1 count", {28'b0, lock_lost_count}, 0);
    repeat (3) step();

    // 2: 3-cycle dropout in RUN is filtered
    locked = 1'b0;
    repeat (3) step();
    locked = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2 sys_reset_n held", {31'b0, sys_reset_n}, 1);
      chk("t2 no pulse", {31'b0, lock_lost}, 0);
    end
    chk("t2 count", {28'b0, lock_lost_count}, 0);

    // 3: confirmed loss
    locked = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k == 5) chk("t3 high at edge 5", {31'b0, sys_reset_n}, 1);
      if (k == 6) begin
        chk("t3 low at edge 6", {31'b0, sys_reset_n}, 0);
        chk("t3 pulse at edge 6", {31'b0, lock_lost}, 1);
        chk("t3 count", {28'b0, lock_lost_count}, 1);
      end
      if (k == 7) chk("t3 pulse one cycle", {31'b0, lock_lost}, 0);
    end
    repeat (2) step();
    acquire("t3 restore");

    // 4: dropout during STABILIZE restarts the stable period
    locked = 1'b0;
    repeat (8) step();
    locked = 1'b1;
    repeat (13) step();
    locked = 1'b0;
    step();
    acquire("t4");

    // 5: saturation and clear interactions
    for (int i = 0; i < 17; i++) do_loss(1'b0);
    chk("t5 saturated", {28'b0, lock_lost_count}, CntMax);
    do_loss(1'b1);
    chk("t5 clear with loss", {28'b0, lock_lost_count}, 1);
    clear_count = 1'b1;
    step();
    clear_count = 1'b0;
    chk("t5 clear alone", {28'b0, lock_lost_count}, 0);

    // 6: asynchronous reset mid-STABILIZE and in RUN
    locked = 1'b0;
    repeat (8) step();
    chk("t6 count before", {28'b0, lock_lost_count}, 1);
    locked = 1'b1;
    repeat (10) step();
    async_reset("t6 stabilize");
    do_loss(1'b0);
    chk("t6 in run", {31'b0, sys_reset_n}, 1);
    async_reset("t6 run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
